// File: rtl/axi_lite_regtest_master.sv
// AXI4-Lite register self-test master: writes LFSR patterns over a register window,
// reads them back, compares, and reports errors and handshake timeouts.
module axi_lite_regtest_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            ADDR_STRIDE        = 4,
  parameter logic [31:0]                   SEED               = 32'h0101FFFF,
  parameter int                            TIMEOUT_CYCLES     = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [7:0]                      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int IW = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD, S_RD_RESP, S_NEXT, S_DONE} state_t;

  state_t          state, state_nx;
  logic [31:0]     lfsr;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   addr;
  logic [TW-1:0]   tcnt;
  logic            mode_r, rd_phase, aw_done, w_done;
  logic            aw_hs, w_hs, tlim, tmo_hit, last;
  logic [1:0]      err_inc;
  logic [8:0]      err_sum;
  logic [DW-1:0]   wdata;

  // Galois form of x^32+x^22+x^2+x+1, shifting right
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    lfsr_next = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  generate
    if (DW == 64) begin : g_w64
      assign wdata = {lfsr, ~lfsr};
    end else begin : g_w32
      assign wdata = lfsr;
    end
  endgenerate

  assign M_AXI_AWADDR  = addr;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = (state == S_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == S_WR) && !w_done;
  assign M_AXI_BREADY  = (state == S_WRESP);
  assign M_AXI_ARVALID = (state == S_RD);
  assign M_AXI_RREADY  = (state == S_RD_RESP);

  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign tlim    = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign last    = (idx == IW'(NUM_REGS - 1));
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign pass    = done && (err_count == 8'd0) && !timeout;
  assign err_sum = {1'b0, err_count} + {7'd0, err_inc};

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    err_inc  = 2'd0;
    case (state)
      S_IDLE:    if (start) state_nx = S_WR;
      S_WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = S_WRESP;
        else if (tlim)                              tmo_hit  = 1'b1;
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          state_nx = mode_r ? S_NEXT : S_RD;
          err_inc  = {1'b0, M_AXI_BRESP != 2'b00};
        end else if (tlim) tmo_hit = 1'b1;
      end
      S_RD: begin
        if (M_AXI_ARREADY) state_nx = S_RD_RESP;
        else if (tlim)     tmo_hit  = 1'b1;
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          state_nx = S_NEXT;
          err_inc  = {1'b0, M_AXI_RDATA != wdata} + {1'b0, M_AXI_RRESP != 2'b00};
        end else if (tlim) tmo_hit = 1'b1;
      end
      S_NEXT: begin
        if (last) state_nx = (mode_r && !rd_phase) ? S_RD : S_DONE;
        else      state_nx = (mode_r && rd_phase)  ? S_RD : S_WR;
      end
      default:   state_nx = S_IDLE;
    endcase
    if (tmo_hit) state_nx = S_DONE;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= S_IDLE;
      lfsr           <= '0;
      idx            <= '0;
      addr           <= '0;
      tcnt           <= '0;
      mode_r         <= 1'b0;
      rd_phase       <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= 8'd0;
      first_err_addr <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= (state_nx != state) ? '0 : tcnt + 1'b1;
      if (state != S_WR) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (tmo_hit) timeout <= 1'b1;
      if (err_inc != 2'd0) begin
        err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
        if (err_count == 8'd0) first_err_addr <= addr;
      end
      case (state)
        S_IDLE: if (start) begin
          lfsr           <= SEED;
          idx            <= '0;
          addr           <= BASE_ADDR;
          mode_r         <= mode;
          rd_phase       <= 1'b0;
          err_count      <= 8'd0;
          timeout        <= 1'b0;
          first_err_addr <= '0;
        end
        S_NEXT: begin
          if (last && mode_r && !rd_phase) begin
            // write phase finished: replay the same pattern for the read phase
            lfsr     <= SEED;
            idx      <= '0;
            addr     <= BASE_ADDR;
            rd_phase <= 1'b1;
          end else if (!last) begin
            lfsr <= lfsr_next(lfsr);
            idx  <= idx + 1'b1;
            addr <= addr + AW'(ADDR_STRIDE);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
